// File: rtl/tlx_fwd_arbiter_if.sv
// Forward-path bundle: three requester channels, the payload output channel,
// the credit-return strobe and the credit/overflow status seen by the arbiter.
interface tlx_fwd_arbiter_if #(
    parameter int CNT_W = 4
);
    logic             AW_REQ_VALID;
    logic [39:0]      AW_REQ_DATA;
    logic             AW_REQ_READY;
    logic             W_REQ_VALID;
    logic [39:0]      W_REQ_DATA;
    logic             W_REQ_READY;
    logic             AR_REQ_VALID;
    logic [39:0]      AR_REQ_DATA;
    logic             AR_REQ_READY;

    logic             FWD_PAYLOAD_TVALID;
    logic [39:0]      FWD_PAYLOAD_TDATA;
    logic             FWD_PAYLOAD_TREADY;

    logic             CREDIT_VALID;
    logic [2:0]       CREDIT_DATA;

    logic [CNT_W-1:0] CREDIT_AW;
    logic [CNT_W-1:0] CREDIT_W;
    logic [CNT_W-1:0] CREDIT_AR;
    logic             OVERFLOW_ERR;

    modport master (
        output AW_REQ_VALID, AW_REQ_DATA, W_REQ_VALID, W_REQ_DATA,
               AR_REQ_VALID, AR_REQ_DATA, FWD_PAYLOAD_TREADY,
               CREDIT_VALID, CREDIT_DATA,
        input  AW_REQ_READY, W_REQ_READY, AR_REQ_READY,
               FWD_PAYLOAD_TVALID, FWD_PAYLOAD_TDATA,
               CREDIT_AW, CREDIT_W, CREDIT_AR, OVERFLOW_ERR
    );

    modport slave (
        input  AW_REQ_VALID, AW_REQ_DATA, W_REQ_VALID, W_REQ_DATA,
               AR_REQ_VALID, AR_REQ_DATA, FWD_PAYLOAD_TREADY,
               CREDIT_VALID, CREDIT_DATA,
        output AW_REQ_READY, W_REQ_READY, AR_REQ_READY,
               FWD_PAYLOAD_TVALID, FWD_PAYLOAD_TDATA,
               CREDIT_AW, CREDIT_W, CREDIT_AR, OVERFLOW_ERR
    );
endinterface

// File: rtl/tlx_fwd_arbiter.sv
// Credit-gated round-robin arbiter sharing the forward payload stream between AW/W/AR.
// Latency 1 cycle REQ handshake to registered TVALID; READY only while the output slot frees.
module tlx_fwd_arbiter #(
    parameter int CREDIT_INIT = 8,
    parameter int CREDIT_W    = 4
) (
    input  logic              FWD_CLK,
    input  logic              FWD_RESETn,
    tlx_fwd_arbiter_if.slave  bus
);
    localparam logic [CREDIT_W-1:0] CRED_MAX = CREDIT_W'(CREDIT_INIT);
    localparam logic [CREDIT_W-1:0] CRED_ONE = CREDIT_W'(1);
    localparam logic [1:0]          CLS_AR   = 2'd2;

    logic [2:0]               req_vld;
    logic [2:0]               ret;
    logic [2:0]               elig;
    logic [2:0]               full;
    logic [2:0]               grant;
    logic [2:0][CREDIT_W-1:0] cnt;
    logic [1:0]               ptr;
    logic [1:0]               gidx;
    logic [1:0]               cand;
    logic                     found;
    logic                     slot_free;
    logic                     tvalid;
    logic [39:0]              tdata;
    logic [39:0]              sel_dat;
    logic                     ovf;

    function automatic logic [1:0] nxt(input logic [1:0] c);
        return (c >= 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    assign req_vld   = {bus.AR_REQ_VALID, bus.W_REQ_VALID, bus.AW_REQ_VALID};
    assign ret       = bus.CREDIT_VALID ? bus.CREDIT_DATA : 3'b000;
    assign slot_free = !tvalid || bus.FWD_PAYLOAD_TREADY;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            elig[i] = req_vld[i] && (cnt[i] != '0);
            full[i] = (cnt[i] == CRED_MAX);
        end
    end

    // Search starts one past the last winner; grants are masked during reset.
    always_comb begin
        found = 1'b0;
        gidx  = 2'd0;
        grant = 3'b000;
        cand  = nxt(ptr);
        for (int k = 0; k < 3; k++) begin
            if (!found && elig[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
            cand = nxt(cand);
        end
        found = found && slot_free && FWD_RESETn;
        if (found) grant[gidx] = 1'b1;
    end

    always_comb begin
        case (gidx)
            2'd0:    sel_dat = bus.AW_REQ_DATA;
            2'd1:    sel_dat = bus.W_REQ_DATA;
            default: sel_dat = bus.AR_REQ_DATA;
        endcase
    end

    always_ff @(posedge FWD_CLK or negedge FWD_RESETn) begin
        if (!FWD_RESETn) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            ptr    <= CLS_AR;
        end else if (slot_free) begin
            tvalid <= found;
            if (found) begin
                tdata <= sel_dat;
                ptr   <= gidx;
            end
        end
    end

    // A grant and a return in the same cycle cancel, so that case never overflows.
    always_ff @(posedge FWD_CLK or negedge FWD_RESETn) begin
        if (!FWD_RESETn) begin
            cnt <= {3{CRED_MAX}};
            ovf <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (grant[i] && !ret[i]) begin
                    cnt[i] <= cnt[i] - CRED_ONE;
                end else if (ret[i] && !grant[i]) begin
                    if (full[i]) ovf <= 1'b1;
                    else         cnt[i] <= cnt[i] + CRED_ONE;
                end
            end
        end
    end

    assign bus.AW_REQ_READY       = grant[0];
    assign bus.W_REQ_READY        = grant[1];
    assign bus.AR_REQ_READY       = grant[2];
    assign bus.FWD_PAYLOAD_TVALID = tvalid;
    assign bus.FWD_PAYLOAD_TDATA  = tdata;
    assign bus.CREDIT_AW          = cnt[0];
    assign bus.CREDIT_W           = cnt[1];
    assign bus.CREDIT_AR          = cnt[2];
    assign bus.OVERFLOW_ERR       = ovf;
endmodule

// File: tb/tb_tlx_fwd_arbiter.sv
// Directed vector table plus exhaustion/refill and mid-traffic reset sequences.
module tb_tlx_fwd_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    localparam logic [39:0] D_AW = 40'h12_3456_789A;
    localparam logic [39:0] D_W  = 40'h55_AA00_1122;
    localparam logic [39:0] D_AR = 40'hC0_FFEE_0033;

    tlx_fwd_arbiter_if #(.CNT_W(4)) bus ();

    tlx_fwd_arbiter #(.CREDIT_INIT(8), .CREDIT_W(4)) dut (
        .FWD_CLK    (clk),
        .FWD_RESETn (rst_n),
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       aw, w, ar, trdy, cv;
        logic [2:0] cd;
        logic [2:0] e_rdy;
        logic       e_tv;
        logic [1:0] e_cls;
        logic [3:0] e_caw, e_cw, e_car;
        logic       e_ovf;
    } vec_t;

    vec_t vecs [13];

    function automatic logic [39:0] cls_data(input logic [1:0] c);
        case (c)
            2'd0:    return D_AW;
            2'd1:    return D_W;
            default: return D_AR;
        endcase
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] rdy_vec();
        return {bus.AR_REQ_READY, bus.W_REQ_READY, bus.AW_REQ_READY};
    endfunction

    task automatic drive(input logic aw, input logic w, input logic ar,
                         input logic trdy, input logic cv, input logic [2:0] cd);
        bus.AW_REQ_VALID       = aw;
        bus.W_REQ_VALID        = w;
        bus.AR_REQ_VALID       = ar;
        bus.FWD_PAYLOAD_TREADY = trdy;
        bus.CREDIT_VALID       = cv;
        bus.CREDIT_DATA        = cd;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.AW_REQ_DATA = D_AW;
        bus.W_REQ_DATA  = D_W;
        bus.AR_REQ_DATA = D_AR;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

        //          aw   w    ar   trdy cv   cd      rdy     tv   cls   caw  cw   car  ovf
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,3'b000, 3'b001, 1'b1,2'd0, 4'd7,4'd8,4'd8,1'b0};
        vecs[1]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,3'b000, 3'b010, 1'b1,2'd1, 4'd7,4'd7,4'd8,1'b0};
        vecs[2]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,3'b000, 3'b100, 1'b1,2'd2, 4'd7,4'd7,4'd7,1'b0};
        vecs[3]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,3'b000, 3'b001, 1'b1,2'd0, 4'd6,4'd7,4'd7,1'b0};
        vecs[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,3'b000, 3'b000, 1'b1,2'd0, 4'd6,4'd7,4'd7,1'b0};
        vecs[5]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,3'b000, 3'b000, 1'b1,2'd0, 4'd6,4'd7,4'd7,1'b0};
        vecs[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,3'b000, 3'b000, 1'b1,2'd0, 4'd6,4'd7,4'd7,1'b0};
        vecs[7]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,3'b000, 3'b010, 1'b1,2'd1, 4'd6,4'd6,4'd7,1'b0};
        vecs[8]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,3'b001, 3'b001, 1'b1,2'd0, 4'd6,4'd6,4'd7,1'b0};
        vecs[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,3'b110, 3'b000, 1'b0,2'd0, 4'd6,4'd7,4'd8,1'b0};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b1,3'b100, 3'b000, 1'b0,2'd0, 4'd6,4'd7,4'd8,1'b1};
        vecs[11] = '{1'b0,1'b0,1'b1,1'b0,1'b0,3'b000, 3'b100, 1'b1,2'd2, 4'd6,4'd7,4'd7,1'b1};
        vecs[12] = '{1'b1,1'b1,1'b1,1'b1,1'b1,3'b111, 3'b001, 1'b1,2'd0, 4'd6,4'd8,4'd8,1'b1};

        repeat (2) @(posedge clk);
        #1;
        check("reset_tvalid", {39'd0, bus.FWD_PAYLOAD_TVALID}, 40'd0);
        check("reset_tdata", bus.FWD_PAYLOAD_TDATA, 40'd0);
        check("reset_credits", {28'd0, bus.CREDIT_AW, bus.CREDIT_W, bus.CREDIT_AR}, 40'h888);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[n]) begin
            @(negedge clk);
            drive(vecs[n].aw, vecs[n].w, vecs[n].ar, vecs[n].trdy, vecs[n].cv, vecs[n].cd);
            #1;
            check($sformatf("v%0d_ready", n), {37'd0, rdy_vec()}, {37'd0, vecs[n].e_rdy});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_tvalid", n), {39'd0, bus.FWD_PAYLOAD_TVALID}, {39'd0, vecs[n].e_tv});
            check($sformatf("v%0d_tdata", n), bus.FWD_PAYLOAD_TDATA, cls_data(vecs[n].e_cls));
            check($sformatf("v%0d_credit_aw", n), {36'd0, bus.CREDIT_AW}, {36'd0, vecs[n].e_caw});
            check($sformatf("v%0d_credit_w", n), {36'd0, bus.CREDIT_W}, {36'd0, vecs[n].e_cw});
            check($sformatf("v%0d_credit_ar", n), {36'd0, bus.CREDIT_AR}, {36'd0, vecs[n].e_car});
            check($sformatf("v%0d_overflow", n), {39'd0, bus.OVERFLOW_ERR}, {39'd0, vecs[n].e_ovf});
        end

        // Asynchronous reset in the middle of a cycle with all requesters active.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_tvalid", {39'd0, bus.FWD_PAYLOAD_TVALID}, 40'd0);
        check("midrst_tdata", bus.FWD_PAYLOAD_TDATA, 40'd0);
        check("midrst_credits", {28'd0, bus.CREDIT_AW, bus.CREDIT_W, bus.CREDIT_AR}, 40'h888);
        check("midrst_overflow", {39'd0, bus.OVERFLOW_ERR}, 40'd0);
        check("midrst_ready", {37'd0, rdy_vec()}, 40'd0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000);
        rst_n = 1'b1;

        // W alone drains its eight credits, then stalls until a return.
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check($sformatf("exh%0d_w_ready", i), {39'd0, bus.W_REQ_READY}, (i < 8) ? 40'd1 : 40'd0);
            @(posedge clk);
            #1;
            check($sformatf("exh%0d_credit_w", i), {36'd0, bus.CREDIT_W}, (i < 8) ? 40'(7 - i) : 40'd0);
        end
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010);
        #1;
        check("refill_same_cycle_ready", {39'd0, bus.W_REQ_READY}, 40'd0);
        @(posedge clk);
        #1;
        check("refill_credit_w_1", {36'd0, bus.CREDIT_W}, 40'd1);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000);
        #1;
        check("refill_next_ready", {39'd0, bus.W_REQ_READY}, 40'd1);
        @(posedge clk);
        #1;
        check("refill_credit_w_0", {36'd0, bus.CREDIT_W}, 40'd0);
        check("refill_tdata", bus.FWD_PAYLOAD_TDATA, D_W);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tlx_fwd_arbiter.md
# tlx_fwd_arbiter

Credit-gated round-robin arbiter that shares the TLX forward payload stream (40-bit flits) between three AXI-derived requesters: write-address (AW), write-data (W) and read-address (AR). Per-class credits are consumed on each granted flit and replenished from the reverse flow stream, which is already synchronized into the forward clock domain. The block sits between the AXI-to-flit packers and the forward payload channel.

## Interface
- CREDIT_INIT, 8: per-class credits loaded at reset; also the per-class maximum (1..15).
- CREDIT_W, 4: width of each credit counter.

- FWD_CLK  in  1  forward-domain clock; all logic rising-edge.
- FWD_RESETn  in  1  reset, asynchronous assert, active-low.
- AW_REQ_VALID / W_REQ_VALID / AR_REQ_VALID  in  1 each  requester has a flit.
- AW_REQ_DATA / W_REQ_DATA / AR_REQ_DATA  in  40 each  requester flit.
- AW_REQ_READY / W_REQ_READY / AR_REQ_READY  out  1 each  grant; flit taken when VALID&READY.
- FWD_PAYLOAD_TVALID  out  1  output flit valid (registered).
- FWD_PAYLOAD_TDATA  out  40  output flit (registered).
- FWD_PAYLOAD_TREADY  in  1  downstream accepts flit.
- CREDIT_VALID  in  1  credit return strobe (from reverse flow stream).
- CREDIT_DATA  in  3  bit0 = AW, bit1 = W, bit2 = AR; each set bit returns one credit.
- CREDIT_AW / CREDIT_W / CREDIT_AR  out  CREDIT_W each  current credit counts.
- OVERFLOW_ERR  out  1  sticky: a credit was returned to a full counter.

## Operation
- Eligible class: REQ_VALID=1 and credit count > 0.
- Output slot is "free" when FWD_PAYLOAD_TVALID=0, or when FWD_PAYLOAD_TVALID & FWD_PAYLOAD_TREADY in the current cycle.
- Grant: when the slot is free and at least one class is eligible, exactly one REQ_READY is driven high, combinationally, for the round-robin winner. All REQ_READY are 0 when the slot is not free.
- Round-robin: a 2-bit last-grant pointer, states AW, W, AR. Search order starts at the class after the pointer (AW→W→AR→AW). The pointer updates only on a grant. Reset value is AR, so AW has first priority.
- On a grant, the winner's DATA is loaded into FWD_PAYLOAD_TDATA and TVALID=1 at the next edge. If the slot frees with no grant, TVALID=0 at the next edge. TDATA holds its value while TVALID & !TREADY.
- Credits, per class, each cycle: −1 on grant; +1 on CREDIT_VALID & the class bit. Both in one cycle gives a net 0.
- If a return would exceed CREDIT_INIT, the count holds at CREDIT_INIT and OVERFLOW_ERR sets. OVERFLOW_ERR clears only on reset.
- Credit-return bits for multiple classes in one cycle are all applied.
- A class at 0 credits is skipped. A return arriving in the same cycle does not make it eligible until the next cycle, because eligibility uses the registered count.
- Reset values: FWD_PAYLOAD_TVALID=0, FWD_PAYLOAD_TDATA=0, all credit counts=CREDIT_INIT, OVERFLOW_ERR=0, pointer=AR. REQ_READY=0 while FWD_RESETn=0.
- Reset mid-transfer: any pending output flit is dropped. Credits reload to CREDIT_INIT.

## Timing
- Latency: REQ handshake at edge N puts the flit on FWD_PAYLOAD_TDATA with TVALID=1 after edge N.
- Throughput: one flit per cycle while TREADY=1 and credits are available.
- REQ_READY depends combinationally on REQ_VALID, the registered counts, the pointer, TVALID and TREADY. There is no combinational path from REQ_DATA to any output.
- Requesters must hold VALID and DATA stable until READY. The arbiter never withdraws a grant within a cycle.

## Test plan
- Reset: assert FWD_RESETn=0 mid-traffic. Required: TVALID=0, TDATA=0, credits=8/8/8, OVERFLOW_ERR=0, all READY=0.
- Single AW flit 0x12_3456_789A with TREADY=1. Required: AW_REQ_READY=1 that cycle; the flit appears with TVALID=1 one cycle later; CREDIT_AW=7.
- Round-robin: all three VALID continuously, TREADY=1. Required: output class order AW, W, AR, AW, W, AR…; each count decrements once per grant.
- Exhaustion: only W valid, no returns. Required: exactly 8 W flits, then W_REQ_READY=0. Then CREDIT_VALID with CREDIT_DATA=3'b010. Required: W granted in the next cycle; CREDIT_W goes 0→1→0.
- Simultaneous consume and return: AW granted in the same cycle as CREDIT_DATA=3'b001. Required: CREDIT_AW unchanged.
- Backpressure and overflow:
  - TREADY=0 for 3 cycles with TVALID=1. Required: TDATA stable and no READY asserted.
  - Return CREDIT_DATA=3'b100 while CREDIT_AR=8. Required: CREDIT_AR stays 8 and OVERFLOW_ERR=1 until reset.
